lcd_line_driver: RTL and testbench

Reader-side LCD engine for the measurement display path. It fetches 20 character codes, addresses 0..19, from the display-text ROM through the ROM address/data pass-through and writes them to an HD44780-compatible character LCD on an 8-bit parallel bus. The block owns the LCD power-up and initialisation sequence and all bus timing. It sits between the text ROM interface and the LCD pins.

---
 rtl/lcd_pkg.sv | 16 +
 rtl/lcd_write_phy.sv | 80 ++++++++
 rtl/lcd_line_driver.sv | 132 +++++++++++++
 tb/tb_lcd_line_driver.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: HD44780 command codes, line length and state encodings shared by the LCD line driver.
package lcd_pkg;
    localparam logic [7:0] FUNC_SET   = 8'h38;
    localparam logic [7:0] DISP_ON    = 8'h0C;
    localparam logic [7:0] ENTRY_MODE = 8'h06;
    localparam logic [7:0] CLEAR      = 8'h01;
    localparam logic [7:0] DDRAM_L1   = 8'h80;
    localparam int LINE_LEN = 20;
    typedef enum logic [3:0] {
        S_PWRUP, S_INIT, S_INIT_W, S_IDLE, S_SETADDR, S_SET_W, S_FETCH, S_LOAD, S_DATA_W
    } state_e;
    typedef enum logic [1:0] {P_IDLE, P_SETUP, P_EN, P_WAIT} phy_e;
    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        return i == 2'd0 ? FUNC_SET : i == 2'd1 ? DISP_ON : i == 2'd2 ? ENTRY_MODE : CLEAR;
    endfunction
endpackage

// File: rtl/lcd_write_phy.sv
// lcd_write_phy: one LCD bus write -- a setup cycle with rs/data registered, an EN pulse, then the
// command wait; ack marks the last wait cycle.
module lcd_write_phy
    import lcd_pkg::*;
#(
    parameter int EN_CYC  = 25,
    parameter int CMD_CYC = 2_500,
    parameter int CLR_CYC = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic [7:0] lcd_data,
    output logic       ack
);
    localparam int MAXC = CLR_CYC > CMD_CYC ? (CLR_CYC > EN_CYC ? CLR_CYC : EN_CYC)
                                            : (CMD_CYC > EN_CYC ? CMD_CYC : EN_CYC);
    localparam int CW = $clog2(MAXC + 1);
    phy_e phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic rs_q, rs_d, en_q, en_d, long_q, long_d;
    logic [7:0] data_q, data_d;
    always_comb begin
        phase_d = phase_q;
        cnt_d = cnt_q;
        rs_d = rs_q;
        data_d = data_q;
        en_d = en_q;
        long_d = long_q;
        ack = 1'b0;
        case (phase_q)
            P_IDLE: if (req) begin
                rs_d = rs;
                data_d = data;
                long_d = long_wait;
                phase_d = P_SETUP;
            end
            P_SETUP: begin
                en_d = 1'b1;
                cnt_d = CW'(EN_CYC - 1);
                phase_d = P_EN;
            end
            P_EN: if (cnt_q == '0) begin
                en_d = 1'b0;
                cnt_d = long_q ? CW'(CLR_CYC - 1) : CW'(CMD_CYC - 1);
                phase_d = P_WAIT;
            end else cnt_d = cnt_q - 1'b1;
            P_WAIT: if (cnt_q == '0) begin
                ack = 1'b1;
                phase_d = P_IDLE;
            end else cnt_d = cnt_q - 1'b1;
            default: phase_d = P_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= P_IDLE;
            cnt_q <= '0;
            rs_q <= 1'b0;
            data_q <= 8'h00;
            en_q <= 1'b0;
            long_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q <= cnt_d;
            rs_q <= rs_d;
            data_q <= data_d;
            en_q <= en_d;
            long_q <= long_d;
        end
    end
    assign lcd_rs = rs_q;
    assign lcd_en = en_q;
    assign lcd_data = data_q;
endmodule

// File: rtl/lcd_line_driver.sv
// lcd_line_driver: power-up, init and line-1 redraw of 20 ROM characters to an HD44780 LCD.
// Define LCD_AUTO_REFRESH_EN to add a periodic redraw every REFRESH_CYC cycles after init.
module lcd_line_driver
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYC = 750_000,
    parameter int EN_CYC      = 25,
    parameter int CMD_CYC     = 2_500,
    parameter int CLR_CYC     = 100_000,
    parameter int REFRESH_CYC = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       refresh,
    output logic [4:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data,
    output logic       busy,
    output logic       done
);
    localparam int PW_W = $clog2(POWERUP_CYC + 1);
    state_e state_q, state_d;
    logic [PW_W-1:0] pw_q, pw_d;
    logic [1:0] init_q, init_d;
    logic [4:0] idx_q, idx_d;
    logic pend_q, pend_d, done_q, done_d;
    logic req, rs, long_wait, ack, tick, last;
    logic [7:0] wdata;
    assign last = idx_q == 5'(LINE_LEN - 1);
    always_comb begin
        state_d = state_q;
        pw_d = pw_q;
        init_d = init_q;
        idx_d = idx_q;
        done_d = 1'b0;
        req = 1'b0;
        rs = 1'b0;
        long_wait = 1'b0;
        wdata = init_cmd(init_q);
        pend_d = pend_q | refresh | tick;
        case (state_q)
            S_PWRUP: if (pw_q == PW_W'(POWERUP_CYC - 1)) state_d = S_INIT;
                     else pw_d = pw_q + 1'b1;
            S_INIT: begin
                req = 1'b1;
                long_wait = init_q == 2'd3;
                state_d = S_INIT_W;
            end
            S_INIT_W: if (ack) begin
                init_d = init_q + 2'd1;
                state_d = init_q == 2'd3 ? S_IDLE : S_INIT;
            end
            S_IDLE: if (pend_q) state_d = S_SETADDR;
            // a refresh landing on the clearing cycle must survive
            S_SETADDR: begin
                req = 1'b1;
                wdata = DDRAM_L1;
                pend_d = refresh | tick;
                state_d = S_SET_W;
            end
            S_SET_W: if (ack) state_d = S_FETCH;
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                req = 1'b1;
                rs = 1'b1;
                wdata = rom_data;
                state_d = S_DATA_W;
            end
            S_DATA_W: if (ack) begin
                done_d = last;
                idx_d = last ? 5'd0 : idx_q + 5'd1;
                state_d = last ? S_IDLE : S_FETCH;
            end
            default: state_d = S_PWRUP;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_PWRUP;
            pw_q <= '0;
            init_q <= 2'd0;
            idx_q <= 5'd0;
            pend_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pw_q <= pw_d;
            init_q <= init_d;
            idx_q <= idx_d;
            pend_q <= pend_d;
            done_q <= done_d;
        end
    end
`ifdef LCD_AUTO_REFRESH_EN
    localparam int RF_W = $clog2(REFRESH_CYC + 1);
    logic [RF_W-1:0] ref_q, ref_d;
    always_comb begin
        ref_d = ref_q + 1'b1;
        tick = 1'b0;
        if (state_q inside {S_PWRUP, S_INIT, S_INIT_W}) ref_d = '0;
        else if (ref_q == RF_W'(REFRESH_CYC - 1)) begin
            ref_d = '0;
            tick = 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ref_q <= '0;
        else ref_q <= ref_d;
    end
`else
    assign tick = 1'b0;
`endif
    lcd_write_phy #(.EN_CYC(EN_CYC), .CMD_CYC(CMD_CYC), .CLR_CYC(CLR_CYC)) u_phy (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .rs(rs),
        .data(wdata),
        .long_wait(long_wait),
        .lcd_rs(lcd_rs),
        .lcd_en(lcd_en),
        .lcd_data(lcd_data),
        .ack(ack)
    );
    assign rom_addr = idx_q;
    assign lcd_rw = 1'b0;
    assign busy = state_q != S_IDLE;
    assign done = done_q;
endmodule

// File: tb/tb_lcd_line_driver.sv
// tb_lcd_line_driver: scoreboard bench for lcd_line_driver with short timing parameters.
module tb_lcd_line_driver;
    localparam int PWR = 10, EN = 2, CMD = 4, CLR = 8, REF = 200;
    logic clk = 1'b0, rst_n = 1'b0, refresh = 1'b0;
    logic [4:0] rom_addr;
    logic [7:0] rom_data = 8'h00;
    logic lcd_rs, lcd_rw, lcd_en, busy, done;
    logic [7:0] lcd_data;
    int checks = 0, errors = 0;
    int done_cnt = 0, cyc = 0;
    bit addr_oob = 1'b0;
    logic [8:0] exp_q[$];
    logic en_prev = 1'b0;
    logic [8:0] bus_prev = 9'd0, bus, exp_w;
    int hi = 0, lo = 0, need = 0;

    lcd_line_driver #(.POWERUP_CYC(PWR), .EN_CYC(EN), .CMD_CYC(CMD), .CLR_CYC(CLR),
                      .REFRESH_CYC(REF)) dut (
        .clk(clk), .rst_n(rst_n), .refresh(refresh), .rom_addr(rom_addr), .rom_data(rom_data),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_data <= 8'h41 + {3'b000, rom_addr};

    // Bus monitor: pops the scoreboard on every EN rise and checks pulse width, setup and hold.
    initial forever begin
        @(negedge clk);
        bus = {lcd_rs, lcd_data};
        if (!rst_n) begin
            en_prev = 1'b0; hi = 0; lo = 0; need = 0; bus_prev = bus;
        end else begin
            if (rom_addr > 5'd19) addr_oob = 1'b1;
            if (done === 1'b1) done_cnt++;
            if (lcd_en && !en_prev) begin
                if (need > 0) begin
                    checks++;
                    if (lo < need) begin errors++; $display("FAIL wait: low cycles %0d want >= %0d", lo, need); end
                    need = 0;
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL write: unexpected rs/data %h", bus);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (bus !== exp_w) begin errors++; $display("FAIL write: got rs/data %h want %h", bus, exp_w); end
                end
                checks++;
                if (bus !== bus_prev || lcd_rw !== 1'b0) begin
                    errors++; $display("FAIL setup: bus %h prev %h rw %b want stable, rw 0", bus, bus_prev, lcd_rw);
                end
                hi = 1;
            end else if (lcd_en) begin
                hi++;
                checks++;
                if (bus !== bus_prev) begin errors++; $display("FAIL hold_en: bus %h want %h", bus, bus_prev); end
            end else if (en_prev) begin
                checks++;
                if (hi != EN || bus !== bus_prev) begin
                    errors++; $display("FAIL en_pulse: width %0d want %0d, bus %h want %h", hi, EN, bus, bus_prev);
                end
                need = (bus_prev == 9'h001) ? CLR : CMD;
                lo = 1;
            end else if (need > 0) begin
                if (bus !== bus_prev) begin
                    checks++;
                    if (lo < need) begin errors++; $display("FAIL hold_wait: stable %0d want >= %0d", lo, need); end
                    need = 0;
                end else lo++;
            end
            en_prev = lcd_en;
            bus_prev = bus;
        end
    end

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
    endtask

    task automatic push_redraw();
        exp_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < 20; i++) exp_q.push_back({1'b1, 8'h41 + 8'(i)});
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        ok = done === 1'b1;
    endtask

    task automatic test_reset();
        int en_seen;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rom_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", rom_addr); end
        checks++; if (lcd_rs !== 1'b0) begin errors++; $display("FAIL reset_rs: got %b want 0", lcd_rs); end
        checks++; if (lcd_rw !== 1'b0) begin errors++; $display("FAIL reset_rw: got %b want 0", lcd_rw); end
        checks++; if (lcd_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", lcd_en); end
        checks++; if (lcd_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", lcd_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        exp_q.delete();
        push_init();
        push_redraw();
        rst_n = 1'b1;
        en_seen = 0;
        repeat (PWR) begin @(negedge clk); if (lcd_en !== 1'b0) en_seen++; end
        checks++; if (en_seen != 0) begin errors++; $display("FAIL pwrup_quiet: en high %0d cycles want 0", en_seen); end
    endtask

    task automatic test_init_redraw();
        bit ok;
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL init_done: done not seen, want pulse"); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %b want 0", busy); end
        checks++; if (rom_addr !== 5'd0) begin errors++; $display("FAIL addr_end: got %0d want 0", rom_addr); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL init_queue: %0d left want 0", exp_q.size()); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_width: got %b want 0", done); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL done_count: got %0d want 1", done_cnt); end
        checks++; if (addr_oob) begin errors++; $display("FAIL addr_range: rom_addr went past 19, want <= 19"); end
    endtask

    task automatic test_refresh_collapse();
        bit ok1, ok2;
        int d0, n;
        d0 = done_cnt;
        push_redraw();
        pulse_refresh();
        n = 0;
        while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL refresh_start: busy %b want 1", busy); end
        repeat (20) @(negedge clk);
        push_redraw();
        for (int k = 0; k < 3; k++) begin pulse_refresh(); repeat (5) @(negedge clk); end
        wait_done(ok1);
        @(negedge clk);
        wait_done(ok2);
        checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL collapse_done: got %b%b want 11", ok1, ok2); end
        repeat (60) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL collapse_idle: busy %b want 0", busy); end
        checks++; if (done_cnt != d0 + 2) begin errors++; $display("FAIL collapse_count: got %0d want %0d", done_cnt - d0, 2); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL collapse_queue: %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_refresh_race();
        bit ok1, ok2;
        int d0;
        d0 = done_cnt;
        push_redraw();
        push_redraw();
        pulse_refresh();
        @(negedge clk);
        pulse_refresh();
        wait_done(ok1);
        @(negedge clk);
        wait_done(ok2);
        checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL race_done: got %b%b want 11", ok1, ok2); end
        repeat (300) @(negedge clk);
        checks++; if (done_cnt != d0 + 2) begin errors++; $display("FAIL race_count: got %0d want %0d", done_cnt - d0, 2); end
        checks++; if (exp_q.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL race_idle: queue %0d busy %b want 0 0", exp_q.size(), busy);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n, en_seen;
        push_redraw();
        pulse_refresh();
        n = 0;
        while (rom_addr !== 5'd7 && n < 1000) begin @(negedge clk); n++; end
        checks++; if (rom_addr !== 5'd7) begin errors++; $display("FAIL mid_reach: addr %0d want 7", rom_addr); end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({lcd_en, lcd_rs, lcd_data} !== 10'd0) begin
            errors++; $display("FAIL async_lcd: en %b rs %b data %h want 0 0 00", lcd_en, lcd_rs, lcd_data);
        end
        checks++; if ({rom_addr, busy, done} !== 7'b00000_1_0) begin
            errors++; $display("FAIL async_ctl: addr %0d busy %b done %b want 0 1 0", rom_addr, busy, done);
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        push_init();
        push_redraw();
        rst_n = 1'b1;
        en_seen = 0;
        repeat (PWR) begin @(negedge clk); if (lcd_en !== 1'b0) en_seen++; end
        checks++; if (en_seen != 0) begin errors++; $display("FAIL mid_pwrup: en high %0d cycles want 0", en_seen); end
        wait_done(ok);
        checks++; if (!ok || exp_q.size() != 0) begin
            errors++; $display("FAIL mid_restart: done %b queue %0d want 1 0", ok, exp_q.size());
        end
        checks++; if (addr_oob) begin errors++; $display("FAIL mid_range: rom_addr went past 19, want <= 19"); end
    endtask

`ifdef LCD_AUTO_REFRESH_EN
    task automatic test_auto_refresh();
        int t[3];
        int n;
        bit ok;
        for (int k = 0; k < 3; k++) begin
            push_redraw();
            n = 0;
            while (busy !== 1'b1 && n < 400) begin @(negedge clk); n++; end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL auto_start%0d: busy %b want 1", k, busy); end
            t[k] = cyc;
            wait_done(ok);
            checks++; if (!ok) begin errors++; $display("FAIL auto_done%0d: done not seen, want pulse", k); end
            @(negedge clk);
        end
        checks++; if (t[1] - t[0] != REF) begin errors++; $display("FAIL auto_period1: got %0d want %0d", t[1] - t[0], REF); end
        checks++; if (t[2] - t[1] != REF) begin errors++; $display("FAIL auto_period2: got %0d want %0d", t[2] - t[1], REF); end
    endtask
`endif

    initial begin
        test_reset();
        test_init_redraw();
`ifdef LCD_AUTO_REFRESH_EN
        test_auto_refresh();
`else
        test_refresh_collapse();
        test_refresh_race();
        test_reset_mid();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
